// File: rtl/exc_commit_ctrl.sv
// Commit-stage trap/ERTN sequencer: picks the winning cause at WB, strobes the CSR file,
// flushes the pipe and hands the redirect target to fetch over valid/ready.
module exc_commit_ctrl #(
  parameter int unsigned EXC_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 wb_valid,
  input  logic [31:0]          wb_pc,
  input  logic [4:0]           wb_exc,
  input  logic                 wb_ertn,
  input  logic                 has_int,
  input  logic [31:0]          csr_eentry_pc,
  input  logic [31:0]          csr_eertn_pc,
  input  logic                 redirect_ready,
  output logic                 wb_ready,
  output logic                 wb_commit,
  output logic [5:0]           csr_exc,
  output logic                 csr_ertn_flush,
  output logic [31:0]          csr_wb_pc,
  output logic                 pipe_flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic [EXC_CNT_W-1:0] exc_count
);

  localparam int unsigned PC_W    = 32;
  localparam int unsigned CAUSE_W = 6;

  // wb_exc bit positions
  localparam int unsigned E_ADEF = 4;
  localparam int unsigned E_ALE  = 3;
  localparam int unsigned E_BRK  = 2;
  localparam int unsigned E_INE  = 1;
  localparam int unsigned E_SYS  = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_REDIR
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 int_req_q;
  logic [CAUSE_W-1:0]   cause_q;
  logic                 ertn_q;
  logic [PC_W-1:0]      pc_q;
  logic [PC_W-1:0]      tgt_q;
  logic [EXC_CNT_W-1:0] cnt_q;

  logic                 trig_c;
  logic                 is_ertn_c;
  logic [CAUSE_W-1:0]   cause_c;

  // Trigger is only meaningful while idle; cause order is INT, ADEF, INE, BRK, SYS, ALE.
  always_comb begin
    cause_c   = '0;
    trig_c    = (state_q == S_IDLE) & wb_valid & (int_req_q | (|wb_exc) | wb_ertn);
    is_ertn_c = wb_ertn & ~int_req_q & ~(|wb_exc);
    if (int_req_q)           cause_c = 6'b100000;
    else if (wb_exc[E_ADEF]) cause_c = 6'b010000;
    else if (wb_exc[E_INE])  cause_c = 6'b000010;
    else if (wb_exc[E_BRK])  cause_c = 6'b000100;
    else if (wb_exc[E_SYS])  cause_c = 6'b000001;
    else if (wb_exc[E_ALE])  cause_c = 6'b001000;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state and handshake/strobe outputs
  always_comb begin
    state_d        = state_q;
    wb_ready       = 1'b0;
    wb_commit      = 1'b0;
    csr_exc        = '0;
    csr_ertn_flush = 1'b0;
    pipe_flush     = 1'b0;
    redirect_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        wb_ready  = 1'b1;
        wb_commit = wb_valid & ~trig_c;
        if (trig_c) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // A reset landing on this cycle must not let the CSR file record a trap.
        csr_exc        = (resetn && !ertn_q) ? cause_q : '0;
        csr_ertn_flush = resetn & ertn_q;
        pipe_flush     = 1'b1;
        state_d        = S_REDIR;
      end
      S_REDIR: begin
        redirect_valid = 1'b1;
        pipe_flush     = 1'b1;
        if (redirect_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Captured trap context, interrupt sampler and statistics
  always_ff @(posedge clk) begin
    if (!resetn) begin
      int_req_q <= 1'b0;
      cause_q   <= '0;
      ertn_q    <= 1'b0;
      pc_q      <= '0;
      tgt_q     <= '0;
      cnt_q     <= '0;
    end else begin
      int_req_q <= (trig_c && int_req_q) ? 1'b0 : has_int;
      if (trig_c) begin
        cause_q <= cause_c;
        ertn_q  <= is_ertn_c;
        pc_q    <= wb_pc;
      end
      // ERA is read here, before the CSR update at the end of this cycle overwrites it.
      if (state_q == S_FLUSH) begin
        tgt_q <= ertn_q ? csr_eertn_pc : csr_eentry_pc;
        if (!ertn_q) cnt_q <= cnt_q + EXC_CNT_W'(1);
      end
    end
  end

  assign csr_wb_pc   = pc_q;
  assign redirect_pc = tgt_q;
  assign exc_count   = cnt_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboard bench for exc_commit_ctrl: tasks push expected strobes/targets, a negedge monitor pops them.
module tb_exc_commit_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [4:0]  wb_exc;
  logic        wb_ertn;
  logic        has_int;
  logic [31:0] csr_eentry_pc;
  logic [31:0] csr_eertn_pc;
  logic        redirect_ready;

  logic        wb_ready, wb_commit, csr_ertn_flush, pipe_flush, redirect_valid;
  logic [5:0]  csr_exc;
  logic [31:0] csr_wb_pc, redirect_pc;
  logic [15:0] exc_count;

  logic        w4_wb_ready, w4_wb_commit, w4_csr_ertn_flush, w4_pipe_flush, w4_redirect_valid;
  logic [5:0]  w4_csr_exc;
  logic [31:0] w4_csr_wb_pc, w4_redirect_pc;
  logic [3:0]  w4_exc_count;

  typedef struct packed {
    logic [5:0]  exc;
    logic        ertn;
    logic [31:0] pc;
    logic [31:0] tgt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cnt_exp = 0;
  logic        redir_pending = 1'b0;
  logic [31:0] exp_tgt = '0;

  always #5 clk = ~clk;

  exc_commit_ctrl #(.EXC_CNT_W(16)) u_dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc(wb_exc),
    .wb_ertn(wb_ertn), .has_int(has_int), .csr_eentry_pc(csr_eentry_pc),
    .csr_eertn_pc(csr_eertn_pc), .redirect_ready(redirect_ready), .wb_ready(wb_ready),
    .wb_commit(wb_commit), .csr_exc(csr_exc), .csr_ertn_flush(csr_ertn_flush),
    .csr_wb_pc(csr_wb_pc), .pipe_flush(pipe_flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .exc_count(exc_count)
  );

  exc_commit_ctrl #(.EXC_CNT_W(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc(wb_exc),
    .wb_ertn(wb_ertn), .has_int(has_int), .csr_eentry_pc(csr_eentry_pc),
    .csr_eertn_pc(csr_eertn_pc), .redirect_ready(redirect_ready), .wb_ready(w4_wb_ready),
    .wb_commit(w4_wb_commit), .csr_exc(w4_csr_exc), .csr_ertn_flush(w4_csr_ertn_flush),
    .csr_wb_pc(w4_csr_wb_pc), .pipe_flush(w4_pipe_flush), .redirect_valid(w4_redirect_valid),
    .redirect_pc(w4_redirect_pc), .exc_count(w4_exc_count)
  );

  // Reference: priority INT, ADEF, INE, BRK, SYS, ALE; ERTN only when nothing else is set.
  function automatic exp_t model(input logic [31:0] pc, input logic [4:0] exc, input logic ertn,
                                 input logic intr, input logic [31:0] eentry,
                                 input logic [31:0] eertn);
    exp_t e;
    e.exc = 6'b000000;
    if (intr)        e.exc = 6'b100000;
    else if (exc[4]) e.exc = 6'b010000;
    else if (exc[1]) e.exc = 6'b000010;
    else if (exc[2]) e.exc = 6'b000100;
    else if (exc[0]) e.exc = 6'b000001;
    else if (exc[3]) e.exc = 6'b001000;
    e.ertn = (e.exc == 6'b000000) && ertn;
    e.pc   = pc;
    e.tgt  = e.ertn ? eertn : eentry;
    return e;
  endfunction

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        redir_pending = 1'b0;
      end else begin
        if (csr_exc != 6'b0 || csr_ertn_flush) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected: csr_exc=%b ertn=%b pc=%h", csr_exc, csr_ertn_flush, csr_wb_pc);
          end else begin
            e = q.pop_front();
            if ({csr_exc, csr_ertn_flush, csr_wb_pc} !== {e.exc, e.ertn, e.pc}) begin
              errors++;
              $display("FAIL strobe: got exc=%b ertn=%b pc=%h, want exc=%b ertn=%b pc=%h",
                       csr_exc, csr_ertn_flush, csr_wb_pc, e.exc, e.ertn, e.pc);
            end
            exp_tgt       = e.tgt;
            redir_pending = 1'b1;
          end
        end
        if (redirect_valid && redirect_ready) begin
          checks++;
          if (!redir_pending || redirect_pc !== exp_tgt) begin
            errors++;
            $display("FAIL redirect: got pc=%h pending=%b, want pc=%h", redirect_pc, redir_pending, exp_tgt);
          end
          redir_pending = 1'b0;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one trapping/ERTN instruction for its trigger cycle; returns in FLUSH.
  task automatic launch(input logic [31:0] pc, input logic [4:0] exc, input logic ertn, input logic intr);
    exp_t e;
    e = model(pc, exc, ertn, intr, csr_eentry_pc, csr_eertn_pc);
    q.push_back(e);
    if (!e.ertn) cnt_exp++;
    wb_valid = 1'b1; wb_pc = pc; wb_exc = exc; wb_ertn = ertn;
    #1;
    checks++;
    if (wb_commit !== 1'b0) begin
      errors++;
      $display("FAIL commit_on_trap: got %b want 0", wb_commit);
    end
    @(posedge clk); #1;
    wb_valid = 1'b0; wb_exc = '0; wb_ertn = 1'b0; wb_pc = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (wb_ready !== 1'b1 && n < budget) begin
      cyc(1);
      n++;
    end
    checks++;
    if (wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_timeout: wb_ready=%b after %0d cycles", wb_ready, n);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; wb_valid = 1'b0; wb_pc = '0; wb_exc = '0; wb_ertn = 1'b0; has_int = 1'b0;
    csr_eentry_pc = 32'h1c008000; csr_eertn_pc = '0; redirect_ready = 1'b1;
    cyc(2);
    checks++;
    if ({wb_ready, csr_exc, csr_ertn_flush, pipe_flush, redirect_valid, redirect_pc, csr_wb_pc, exc_count}
        !== {1'b1, 6'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0}) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b exc=%b ertn=%b fl=%b rv=%b rpc=%h wpc=%h cnt=%0d",
               wb_ready, csr_exc, csr_ertn_flush, pipe_flush, redirect_valid, redirect_pc, csr_wb_pc, exc_count);
    end
    checks++;
    if ({w4_wb_ready, w4_csr_exc, w4_csr_ertn_flush, w4_pipe_flush, w4_redirect_valid,
         w4_redirect_pc, w4_csr_wb_pc, w4_exc_count} !== {1'b1, 6'b0, 3'b0, 64'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_outputs_w4: rdy=%b exc=%b rv=%b cnt=%0d", w4_wb_ready, w4_csr_exc,
               w4_redirect_valid, w4_exc_count);
    end
    resetn = 1'b1; wb_valid = 1'b1; wb_pc = 32'h1c000000;
    #1;
    checks++;
    if ({wb_ready, wb_commit, w4_wb_commit} !== 3'b111) begin
      errors++;
      $display("FAIL reset_commit: got rdy=%b commit=%b w4commit=%b want 111", wb_ready, wb_commit, w4_wb_commit);
    end
    cyc(1);
    wb_valid = 1'b0;
    cyc(1);
  endtask

  task automatic test_sys;
    csr_eentry_pc = 32'h1c008000; redirect_ready = 1'b1;
    launch(32'h1c000100, 5'b00001, 1'b0, 1'b0);
    checks++;
    if ({pipe_flush, wb_ready, csr_exc, csr_wb_pc} !== {1'b1, 1'b0, 6'b000001, 32'h1c000100}) begin
      errors++;
      $display("FAIL sys_flush: fl=%b rdy=%b exc=%b pc=%h", pipe_flush, wb_ready, csr_exc, csr_wb_pc);
    end
    cyc(1);
    checks++;
    if ({redirect_valid, redirect_pc, wb_commit, csr_exc} !== {1'b1, 32'h1c008000, 1'b0, 6'b0}
        || exc_count !== 16'(cnt_exp)) begin
      errors++;
      $display("FAIL sys_redir: rv=%b rpc=%h commit=%b exc=%b cnt=%0d want cnt=%0d",
               redirect_valid, redirect_pc, wb_commit, csr_exc, exc_count, cnt_exp);
    end
    cyc(1);
    checks++;
    if ({wb_ready, redirect_valid, pipe_flush} !== 3'b100) begin
      errors++;
      $display("FAIL sys_idle: rdy=%b rv=%b fl=%b want 100", wb_ready, redirect_valid, pipe_flush);
    end
  endtask

  task automatic test_priority;
    has_int = 1'b1;
    cyc(1);
    launch(32'h1c000110, 5'b11000, 1'b0, 1'b1);
    has_int = 1'b0;
    checks++;
    if (csr_exc !== 6'b100000) begin
      errors++;
      $display("FAIL prio_int: got %b want 100000", csr_exc);
    end
    wait_idle(10);
    cyc(1);
    launch(32'h1c000114, 5'b11000, 1'b0, 1'b0);
    checks++;
    if (csr_exc !== 6'b010000) begin
      errors++;
      $display("FAIL prio_adef: got %b want 010000", csr_exc);
    end
    wait_idle(10);
  endtask

  task automatic test_ertn;
    csr_eertn_pc = 32'h1c000104;
    launch(32'h1c000300, 5'b00000, 1'b1, 1'b0);
    cyc(1);
    checks++;
    if (redirect_pc !== 32'h1c000104 || exc_count !== 16'(cnt_exp)) begin
      errors++;
      $display("FAIL ertn_redir: rpc=%h cnt=%0d want rpc=1c000104 cnt=%0d", redirect_pc, exc_count, cnt_exp);
    end
    wait_idle(10);
    launch(32'h1c000304, 5'b00100, 1'b1, 1'b0);
    checks++;
    if ({csr_exc, csr_ertn_flush} !== {6'b000100, 1'b0}) begin
      errors++;
      $display("FAIL ertn_brk: exc=%b ertn=%b want 000100/0", csr_exc, csr_ertn_flush);
    end
    wait_idle(10);
    checks++;
    if (exc_count !== 16'(cnt_exp)) begin
      errors++;
      $display("FAIL ertn_count: got %0d want %0d", exc_count, cnt_exp);
    end
  endtask

  task automatic test_backpressure;
    redirect_ready = 1'b0;
    launch(32'h1c000500, 5'b00010, 1'b0, 1'b0);
    cyc(1);
    csr_eentry_pc = 32'hdead0000;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({redirect_valid, wb_ready, pipe_flush, redirect_pc} !== {3'b101, 32'h1c008000}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rv=%b rdy=%b fl=%b rpc=%h", i, redirect_valid, wb_ready, pipe_flush, redirect_pc);
      end
      cyc(1);
    end
    redirect_ready = 1'b1;
    cyc(1);
    checks++;
    if ({wb_ready, redirect_valid, pipe_flush} !== 3'b100) begin
      errors++;
      $display("FAIL bp_release: rdy=%b rv=%b fl=%b want 100", wb_ready, redirect_valid, pipe_flush);
    end
    csr_eentry_pc = 32'h1c008000;
  endtask

  task automatic test_int_empty;
    has_int = 1'b1; wb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      checks++;
      if ({csr_exc, pipe_flush, wb_ready} !== {6'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL int_empty[%0d]: exc=%b fl=%b rdy=%b", i, csr_exc, pipe_flush, wb_ready);
      end
    end
    launch(32'h1c000200, 5'b00000, 1'b0, 1'b1);
    has_int = 1'b0;
    checks++;
    if ({csr_exc, csr_wb_pc} !== {6'b100000, 32'h1c000200}) begin
      errors++;
      $display("FAIL int_attach: exc=%b pc=%h want 100000/1c000200", csr_exc, csr_wb_pc);
    end
    wait_idle(10);
  endtask

  task automatic test_reset_redir;
    redirect_ready = 1'b0;
    launch(32'h1c000400, 5'b01000, 1'b0, 1'b0);
    cyc(1);
    checks++;
    if (redirect_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: rv=%b want 1", redirect_valid);
    end
    resetn = 1'b0;
    cnt_exp = 0;
    cyc(1);
    checks++;
    if ({wb_ready, csr_exc, csr_ertn_flush, pipe_flush, redirect_valid, redirect_pc, csr_wb_pc, exc_count}
        !== {1'b1, 6'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0}) begin
      errors++;
      $display("FAIL rst_redir: rdy=%b exc=%b fl=%b rv=%b rpc=%h wpc=%h cnt=%0d",
               wb_ready, csr_exc, pipe_flush, redirect_valid, redirect_pc, csr_wb_pc, exc_count);
    end
    resetn = 1'b1; redirect_ready = 1'b1;
    cyc(1);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    launch(32'h1c000600, 5'b00001, 1'b0, 1'b0);
    wb_valid = 1'b1; wb_pc = 32'h1c000604; wb_exc = 5'b00100; wb_ertn = 1'b0;
    e = model(32'h1c000604, 5'b00100, 1'b0, 1'b0, csr_eentry_pc, csr_eertn_pc);
    q.push_back(e);
    cnt_exp++;
    #1;
    checks++;
    if (wb_commit !== 1'b0) begin
      errors++;
      $display("FAIL b2b_flush_commit: got %b want 0", wb_commit);
    end
    cyc(1);
    checks++;
    if ({redirect_valid, wb_commit} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_redir: rv=%b commit=%b want 10", redirect_valid, wb_commit);
    end
    cyc(1);
    checks++;
    if ({wb_ready, wb_commit} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_idle: rdy=%b commit=%b want 10", wb_ready, wb_commit);
    end
    cyc(1);
    checks++;
    if ({csr_exc, csr_wb_pc} !== {6'b000100, 32'h1c000604}) begin
      errors++;
      $display("FAIL b2b_second: exc=%b pc=%h want 000100/1c000604", csr_exc, csr_wb_pc);
    end
    wb_valid = 1'b0; wb_exc = '0; wb_pc = '0;
    wait_idle(10);
  endtask

  task automatic test_wrap;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        er;
    while (cnt_exp < 17) begin
      pc  = $urandom;
      exc = 5'($urandom_range(1, 31));
      er  = 1'($urandom_range(0, 1));
      launch(pc, exc, er, 1'b0);
      wait_idle(10);
    end
    checks++;
    if (exc_count !== 16'd17 || w4_exc_count !== 4'd1) begin
      errors++;
      $display("FAIL wrap: cnt16=%0d cnt4=%0d want 17/1", exc_count, w4_exc_count);
    end
  endtask

  initial begin
    test_reset();
    test_sys();
    test_priority();
    test_ertn();
    test_backpressure();
    test_int_empty();
    test_reset_redir();
    test_back_to_back();
    test_wrap();
    cyc(2);
    checks++;
    if (q.size() != 0 || redir_pending) begin
      errors++;
      $display("FAIL leftover: queued=%0d pending=%b want 0/0", q.size(), redir_pending);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exc_commit_ctrl.md
# exc_commit_ctrl

Commit-stage exception and interrupt sequencer that sits between the WB stage, the CSR file and the fetch unit. It inspects each instruction reaching WB and picks the single highest-priority trap cause. It then drives the CSR file's one-cycle exception/ertn strobes, squashes the pipeline, and delivers the redirect PC (exception entry or ERA) to fetch over a valid/ready handshake. While the sequence is in progress it holds WB.

## Interface
- EXC_CNT_W, 16, width of the wrapping trap statistics counter.

- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- wb_valid  in  1  WB holds a valid instruction.
- wb_pc  in  32  PC of the WB instruction.
- wb_exc  in  5  raw causes {ADEF,ALE,BRK,INE,SYS} carried down the pipe.
- wb_ertn  in  1  WB instruction is ERTN.
- has_int  in  1  CSR-file pending-and-enabled interrupt.
- csr_eentry_pc  in  32  exception entry from the CSR file.
- csr_eertn_pc  in  32  ERA from the CSR file.
- redirect_ready  in  1  fetch accepts the redirect.
- wb_ready  out  1  WB may retire this cycle.
- wb_commit  out  1  WB instruction retires normally (regfile/CSR write permitted).
- csr_exc  out  6  one-hot {INT,ADEF,ALE,BRK,INE,SYS} strobe to the CSR file.
- csr_ertn_flush  out  1  ERTN strobe to the CSR file.
- csr_wb_pc  out  32  PC recorded into ERA.
- pipe_flush  out  1  squash IF..MEM.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  32  redirect target.
- exc_count  out  EXC_CNT_W  number of traps taken, including interrupts but excluding ERTN.

## Operation
- The interrupt sampler is int_req, a register: int_req <= has_int every cycle. It is cleared to 0 when an interrupt is taken, i.e. on the IDLE->FLUSH transition with cause INT.
- The trigger is a combinational signal, trig = wb_valid & (int_req | |wb_exc | wb_ertn), evaluated only in IDLE.
- Cause priority, highest first: INT, ADEF, INE, BRK, SYS, ALE. Exactly one bit is captured into cause_q.
- The ERTN kind applies only when no INT and no exc bit is set. If any exception bit is set, ERTN is ignored.
- FSM has three states: IDLE, FLUSH, REDIR.
  - IDLE: wb_ready=1 and wb_commit = wb_valid & ~trig. If trig, capture cause_q/kind and pc_q <= wb_pc, then go to FLUSH.
  - FLUSH (exactly 1 cycle):
    - On a trap, csr_exc = cause_q; on ERTN, csr_ertn_flush=1.
    - csr_wb_pc = pc_q; pipe_flush=1; wb_ready=0.
    - Capture tgt_q <= (kind==ERTN ? csr_eertn_pc : csr_eentry_pc). The CSR update lands at the end of this cycle, so ERA is read before it is modified.
    - exc_count increments on a trap and wraps modulo 2^EXC_CNT_W.
    - Go to REDIR.
  - REDIR: redirect_valid=1, redirect_pc=tgt_q, pipe_flush=1, wb_ready=0, wb_commit=0. On redirect_valid & redirect_ready, go to IDLE.
- Outside FLUSH, csr_exc=0, csr_ertn_flush=0 and csr_wb_pc=pc_q.
- A trapping or ERTN instruction never asserts wb_commit.
- If an interrupt is pending while WB is empty, the controller waits. The interrupt attaches to the next valid WB instruction, and ERA receives that instruction's PC.

## Timing
- Reset values: FSM=IDLE, int_req=0, exc_count=0, pc_q=0, tgt_q=0, cause_q=0.
  - Hence wb_ready=1 and wb_commit=wb_valid.
  - csr_exc=0, csr_ertn_flush=0, pipe_flush=0, redirect_valid=0, redirect_pc=0, csr_wb_pc=0.
- Latency: trigger in cycle T, CSR strobe in T+1, redirect_valid from T+2 onward. The minimum trap-to-IDLE time is 3 cycles when redirect_ready is held high.
- redirect_valid and redirect_pc stay stable until accepted. redirect_ready while redirect_valid=0 is ignored.
- has_int changes during FLUSH or REDIR only update int_req. They never re-trigger until the FSM is back in IDLE.
- Synchronous reset mid-FLUSH or mid-REDIR returns the block to IDLE next edge, drops redirect_valid, and issues no CSR strobe.
- Back-to-back traps: a trigger present on the IDLE cycle right after REDIR completes is taken normally.

## Test plan
- SYS trap:
  - Stimulus: wb_valid=1, wb_pc=0x1c000100, wb_exc=SYS, csr_eentry_pc=0x1c008000, redirect_ready=1.
  - Response: next cycle csr_exc=6'b000001 for 1 cycle with csr_wb_pc=0x1c000100. Then redirect_valid=1 with redirect_pc=0x1c008000 for 1 cycle. wb_commit stays 0; exc_count=1.
- Priority:
  - Stimulus: wb_exc={ADEF,ALE}=5'b11000 with int_req=1.
  - Response: csr_exc=6'b100000 (INT), and int_req clears.
  - Stimulus: repeat with has_int=0.
  - Response: csr_exc=6'b010000 (ADEF).
- ERTN:
  - Stimulus: wb_ertn=1, wb_exc=0, csr_eertn_pc=0x1c000104.
  - Response: csr_ertn_flush=1 for 1 cycle, redirect_pc=0x1c000104, exc_count unchanged.
  - Stimulus: wb_ertn=1 together with wb_exc=BRK.
  - Response: a BRK trap, with no ertn strobe.
- Fetch backpressure:
  - Stimulus: redirect_ready=0 for 5 cycles, and csr_eentry_pc changes during REDIR.
  - Response: redirect_valid and redirect_pc hold their captured values, wb_ready=0 and pipe_flush=1 throughout, and the block returns to IDLE on the cycle after ready rises.
- Interrupt with an empty WB:
  - Stimulus: has_int=1 while wb_valid=0 for 3 cycles, then a valid instruction at pc 0x1c000200.
  - Response: no strobe while WB is empty, then csr_exc=INT with csr_wb_pc=0x1c000200.
- Reset and counter wrap:
  - Stimulus: assert resetn=0 during REDIR.
  - Response: outputs return to their reset values next edge.
  - Stimulus: EXC_CNT_W=4, take 17 traps.
  - Response: exc_count=1.
